// File: rtl/binary_clock.sv
`timescale 1ns/1ps
// binary_clock: BCD time-of-day clock driving a row-scanned 4x4 LED matrix.
// Define H12_EN for 12-hour mode (resets to 12:00, hours run 12,1..11).
module binary_clock #(
    parameter int TICK_DIV = 12000000,
    parameter int SCAN_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4,
    output logic [1:0] row,
    output logic       sec_tick
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

`ifdef H12_EN
    localparam logic [1:0] H1_RST = 2'd1;
    localparam logic [3:0] H0_RST = 4'd2;
`else
    localparam logic [1:0] H1_RST = 2'd0;
    localparam logic [3:0] H0_RST = 4'd0;
`endif

    logic [TW-1:0] presc, presc_next;
    logic [SW-1:0] scan, scan_next;
    logic [5:0]    sec, sec_next;
    logic [3:0]    m0, m0_next;
    logic [2:0]    m1, m1_next;
    logic [3:0]    h0, h0_next;
    logic [1:0]    h1, h1_next;
    logic [1:0]    row_next;
    logic          tick;
    logic [3:0]    d1, d2, d3, d4;

    // Whole seconds->minutes->hours carry chain resolves in the tick cycle.
    always_comb begin
        tick       = (presc == TICK_LAST);
        presc_next = tick ? '0 : presc + TW'(1);
        sec_next   = sec;
        m0_next    = m0;
        m1_next    = m1;
        h0_next    = h0;
        h1_next    = h1;
        if (tick) begin
            if (sec == 6'd59) begin
                sec_next = '0;
                if (m0 == 4'd9) begin
                    m0_next = '0;
                    if (m1 == 3'd5) begin
                        m1_next = '0;
`ifdef H12_EN
                        if (h1 == 2'd1 && h0 == 4'd2) begin
                            h1_next = 2'd0;
                            h0_next = 4'd1;
                        end
`else
                        if (h1 == 2'd2 && h0 == 4'd3) begin
                            h1_next = 2'd0;
                            h0_next = 4'd0;
                        end
`endif
                        else if (h0 == 4'd9) begin
                            h0_next = 4'd0;
                            h1_next = h1 + 2'd1;
                        end else begin
                            h0_next = h0 + 4'd1;
                        end
                    end else begin
                        m1_next = m1 + 3'd1;
                    end
                end else begin
                    m0_next = m0 + 4'd1;
                end
            end else begin
                sec_next = sec + 6'd1;
            end
        end
    end

    // LEDs are fed from next-state digits and row so both change together.
    always_comb begin
        scan_next = (scan == SCAN_LAST) ? '0 : scan + SW'(1);
        row_next  = (scan == SCAN_LAST) ? row + 2'd1 : row;
        d1        = {2'b00, h1_next};
        d2        = h0_next;
        d3        = {1'b0, m1_next};
        d4        = m0_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            scan     <= '0;
            sec      <= '0;
            m0       <= '0;
            m1       <= '0;
            h0       <= H0_RST;
            h1       <= H1_RST;
            row      <= '0;
            sec_tick <= 1'b0;
            led1     <= 1'b0;
            led2     <= 1'b0;
            led3     <= 1'b0;
            led4     <= 1'b0;
        end else begin
            presc    <= presc_next;
            scan     <= scan_next;
            sec      <= sec_next;
            m0       <= m0_next;
            m1       <= m1_next;
            h0       <= h0_next;
            h1       <= h1_next;
            row      <= row_next;
            sec_tick <= tick;
            led1     <= d1[row_next];
            led2     <= d2[row_next];
            led3     <= d3[row_next];
            led4     <= d4[row_next];
        end
    end

endmodule

// File: tb/tb_binary_clock.sv
`timescale 1ns/1ps
// Self-checking bench for binary_clock: a seconds-of-day model predicts
// row, sec_tick and the four LED columns after every clock edge.
module tb_binary_clock;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;
`ifdef H12_EN
    localparam int DAY = 43200;
`else
    localparam int DAY = 86400;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       led1, led2, led3, led4;
    logic [1:0] row;
    logic       sec_tick;
    logic [6:0] obs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int msecs = 0;

    binary_clock #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .led1(led1), .led2(led2), .led3(led3), .led4(led4),
        .row(row), .sec_tick(sec_tick)
    );

    assign obs = {row, sec_tick, led1, led2, led3, led4};

    always #5 clk = ~clk;

    function automatic int disp_hour(input int s);
        int hr;
        hr = s / 3600;
`ifdef H12_EN
        if (hr == 0) hr = 12;
`endif
        return hr;
    endfunction

    function automatic int model_row();
        return (cyc / SCAN_DIV) % 4;
    endfunction

    // Expected {row, sec_tick, led1..led4} after the most recent edge.
    function automatic logic [6:0] exp_vec();
        int hr, mn, r;
        logic [3:0] l;
        logic t;
        hr = disp_hour(msecs);
        mn = (msecs / 60) % 60;
        r  = model_row();
        l[3] = 1'(((hr / 10) >> r) & 1);
        l[2] = 1'(((hr % 10) >> r) & 1);
        l[1] = 1'(((mn / 10) >> r) & 1);
        l[0] = 1'(((mn % 10) >> r) & 1);
        if (cyc == 0) l = 4'b0000;
        t = (cyc > 0) && (cyc % TICK_DIV == 0);
        return {2'(r), t, l};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_n) begin
            cyc++;
            if (cyc % TICK_DIV == 0) msecs = (msecs + 1) % DAY;
        end
    endtask

    // Jump the time of day by overriding the DUT time registers between edges.
    task automatic preload(input int s);
        int hr, mn;
        @(negedge clk);
        msecs = s;
        hr = disp_hour(s);
        mn = (s / 60) % 60;
        force dut.sec = 6'(s % 60);
        force dut.m0  = 4'(mn % 10);
        force dut.m1  = 3'(mn / 10);
        force dut.h0  = 4'(hr % 10);
        force dut.h1  = 2'(hr / 10);
        #1;
        release dut.sec;
        release dut.m0;
        release dut.m1;
        release dut.h0;
        release dut.h1;
    endtask

    task automatic test_reset();
        int first_tick;
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold got=%b want=%b", obs, 7'b0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        msecs = 0;
        first_tick = -1;
        for (int i = 0; i < 3 * TICK_DIV; i++) begin
            step();
            if (sec_tick === 1'b1 && first_tick < 0) first_tick = cyc;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL reset_run cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
        end
        checks++;
        if (first_tick !== TICK_DIV) begin
            errors++;
            $display("[TB] FAIL first_tick got=%0d want=%0d", first_tick, TICK_DIV);
        end
    endtask

    task automatic test_minute_rollover();
        int seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        int budget;
        budget = 0;
        while (msecs != 60 && budget < 2000) begin
            step();
            budget++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL minute_run cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
        end
        checks++;
        if (msecs != 60) begin
            errors++;
            $display("[TB] FAIL minute_budget got=%0d want=60", msecs);
        end
        while (cyc % (4 * SCAN_DIV) != 0) step();
        for (int i = 0; i < 9; i++) begin
            if (i > 0) step();
            checks++;
            if (row !== 2'(seq[i]) || led4 !== (seq[i] == 0) || led3 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL scan_seq i=%0d got row=%0d led3=%b led4=%b want row=%0d led3=0 led4=%b",
                         i, row, led3, led4, seq[i], seq[i] == 0);
            end
`ifndef H12_EN
            checks++;
            if ({led1, led2} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL scan_hours i=%0d got=%b want=00", i, {led1, led2});
            end
`endif
        end
    endtask

    task automatic test_bcd_carry();
        int budget;
        budget = 0;
        while (msecs != 600 && budget < 5000) begin
            step();
            budget++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL carry10_run cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
        end
        while (model_row() != 0) step();
        checks++;
        if (led3 !== 1'b1 || led4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL carry10_row0 got led3=%b led4=%b want led3=1 led4=0", led3, led4);
        end
        budget = 0;
        while (msecs != 3600 && budget < 20000) begin
            step();
            budget++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL carry60_run cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
        end
        while (model_row() != 0) step();
        checks++;
        if ({led1, led2, led3, led4} !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL carry60_row0 got=%b want=0100", {led1, led2, led3, led4});
        end
    endtask

    task automatic test_day_wrap();
        logic [1:0] want_h;
        preload(DAY - 5);
        for (int i = 0; i < 60; i++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL wrap_run cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
`ifndef H12_EN
            if (msecs == DAY - 1) begin
                want_h = (model_row() == 0) ? 2'b01 : (model_row() == 1) ? 2'b11 : 2'b00;
                checks++;
                if ({led1, led2} !== want_h) begin
                    errors++;
                    $display("[TB] FAIL wrap_235959 row=%0d got=%b want=%b", model_row(), {led1, led2}, want_h);
                end
            end
            if (msecs < 10) begin
                checks++;
                if ({led1, led2, led3, led4} !== 4'b0000) begin
                    errors++;
                    $display("[TB] FAIL wrap_midnight row=%0d got=%b want=0000", model_row(), {led1, led2, led3, led4});
                end
            end
`endif
        end
    endtask

    task automatic test_random_preload();
        int n;
        for (int k = 0; k < 6; k++) begin
            preload(int'($urandom_range(DAY - 1)));
            n = int'($urandom_range(60, 10));
            for (int i = 0; i < n; i++) begin
                step();
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("[TB] FAIL random_run k=%0d cyc=%0d got=%b want=%b", k, cyc, obs, exp_vec());
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int first_tick;
        preload(5 * 3600 + 37 * 60 + 20);
        repeat (int'($urandom_range(30, 5))) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL pre_reset cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
        end
        #($urandom_range(6, 1));
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("[TB] FAIL async_clear got=%b want=%b", obs, 7'b0);
        end
        repeat (2) step();
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("[TB] FAIL async_hold got=%b want=%b", obs, 7'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        msecs = 0;
        first_tick = -1;
        for (int i = 0; i < 3 * TICK_DIV; i++) begin
            step();
            if (sec_tick === 1'b1 && first_tick < 0) first_tick = cyc;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL post_reset cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
`ifdef H12_EN
            checks++;
            if ({led1, led2} !== ((model_row() == 0) ? 2'b10 : (model_row() == 1) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("[TB] FAIL h12_reset_time row=%0d got=%b", model_row(), {led1, led2});
            end
`endif
        end
        checks++;
        if (first_tick !== TICK_DIV) begin
            errors++;
            $display("[TB] FAIL post_reset_tick got=%0d want=%0d", first_tick, TICK_DIV);
        end
    endtask

    initial begin
        test_reset();
        test_minute_rollover();
        test_bcd_carry();
        test_day_wrap();
        test_random_preload();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/binary_clock.md
Name: binary_clock

Overview:
- Free-running 24-hour binary (BCD) clock driving a 4x4 LED matrix.
- Internal timekeeping: seconds, minutes, hours. Display digits: hour-tens (h1), hour-units (h0), minute-tens (m1), minute-units (m0).
- Four column outputs (led1..led4) carry one bit of each digit. A row-scan output selects which bit plane is currently shown.
- Top-level leaf: directly drives FPGA LED pins and the external row driver.

Parameters:
- TICK_DIV, 12000000, clk cycles per one-second tick (≥2).
- SCAN_DIV, 1024, clk cycles per display row (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- led1  out  1  h1 bit [row].
- led2  out  1  h0 bit [row].
- led3  out  1  m1 bit [row].
- led4  out  1  m0 bit [row].
- row  out  2  bit index currently displayed (0 = LSB).
- sec_tick  out  1  one-cycle pulse each second.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, rst_n). All state updates on rising clk.
- Reset values: prescaler=0, seconds=0, time=00:00, scan counter=0, row=0, led1..4=0, sec_tick=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - sec_tick is registered: high for exactly the cycle after prescaler==TICK_DIV-1, so the first pulse appears at cycle TICK_DIV after reset release.
- Seconds: binary 0..59, incremented on each tick.
- Carry chain, all updated in the same clk edge as the causing tick:
  - 59→0 carries to m0.
  - m0 BCD 0..9, 9→0 carries to m1.
  - m1 0..5, 5→0 carries to hours.
  - Hours BCD (h1 0..2, h0 0..9). At h1=2, h0 wraps 3→0 and h1→0.
- 23:59:59 + tick → 00:00:00. No illegal BCD value is ever reachable.
- Widths: h1 2 bits, zero-extended to 4 for display; h0, m1, m0 4 bits; m1 is 3 bits internally, zero-extended.
- Scan:
  - Counter 0..SCAN_DIV-1. At wrap, row increments mod 4 (3→0).
- Outputs:
  - led1..4 registered: led_n <= digit_n[row_next]. Outputs always reflect the current row value and the current time.
  - If time and row change on the same edge, outputs show the new time on the new row.
  - One cycle of latency from time/row change to led update is acceptable only if row and leds stay coherent. Required implementation: compute from next-state values so row and leds update together.
- Reset asserted mid-count clears all state immediately (asynchronous). Counting resumes from zero on the first edge after release.

Optional Feature:
- Macro H12_EN.
- Defined: 12-hour mode.
  - Reset time is 12:00.
  - Hours sequence 12→01→…→11→12, i.e. 12:59:59 + tick → 01:00:00.
  - h1 ∈ {0,1}. No AM/PM indicator.
- Undefined: 24-hour behaviour as above.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then release → row=0, leds=0000, sec_tick=0. First sec_tick occurs exactly TICK_DIV cycles after release. Run with TICK_DIV=4, SCAN_DIV=2.
- Minute rollover: 60 ticks from reset → time 00:01. At row=0, led4=1 and led1..3=0. At rows 1–3, all leds=0.
- Scan: with time 00:01 and SCAN_DIV=2 → row sequence 0,0,1,1,2,2,3,3,0 on consecutive cycles. led4 high only while row=0.
- BCD carry: advance to 00:09:59 + 1 tick → 00:10. Row 0 shows led3=1, led4=0. Advance to 00:59:59 + tick → 01:00.
- Day wrap: advance to 23:59:59 (leds at row1: led1=1 for h1=2; row0: led2=1, row1: led2=1 for h0=3) + tick → 00:00:00, all leds 0 on every row.
- Async reset mid-operation: assert rst_n=0 between clock edges at time 05:37 → all outputs 0 before the next edge. After release, first sec_tick again arrives TICK_DIV cycles later. With H12_EN, the reset time reads 12:00 (row0: led1=1; row1: led2=1).
